// File: rtl/elevator_pkg.sv
// Shared definitions for the four-floor elevator scheduler.
//   motor_e   : motor command encodings (STOP / UP / DOWN; 2'b11 is never used)
//   state_e   : scheduler FSM states
//   motor_of  : motor command belonging to each state
//   pending_above / pending_below : is any call latched strictly above / below a floor
package elevator_pkg;

    localparam int         NUM_FLOORS   = 4;
    localparam logic [1:0] TOP_FLOOR    = 2'd3;
    localparam logic [1:0] BOTTOM_FLOOR = 2'd0;

    typedef enum logic [1:0] {
        MOTOR_STOP = 2'b00,
        MOTOR_UP   = 2'b01,
        MOTOR_DOWN = 2'b10
    } motor_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN,
        ST_DOOR,
        ST_FAULT
    } state_e;

    function automatic motor_e motor_of(input state_e st);
        case (st)
            ST_UP:   return MOTOR_UP;
            ST_DOWN: return MOTOR_DOWN;
            default: return MOTOR_STOP;
        endcase
    endfunction

    function automatic logic pending_above(input logic [3:0] pend, input logic [1:0] flr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(flr) && pend[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic pending_below(input logic [3:0] pend, input logic [1:0] flr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(flr) && pend[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter with a zero flag, used for the door dwell and the
// travel timeout.
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   load       : load load_value this edge (wins over counting)
//   en         : decrement by one per edge, saturating at zero
//   load_value : value taken on load
//   zero       : count is zero
module elev_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// Four-floor SCAN elevator scheduler.
//   clk, rst       : clock, asynchronous active-high reset
//   select_floor   : call buttons, bit i = floor i (level, >= 1 cycle)
//   s4..s1         : floor sensors, high while the cab is at floor 3..0
//   motor          : 00 stop, 01 up, 10 down (registered)
//   floor          : last valid floor reached
//   pending        : latched outstanding calls
//   door_open      : high during the dwell at a floor
//   fault          : travel timeout, sticky until reset
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int DWELL_CYCLES   = 25000000,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] select_floor,
    input  logic       s4,
    input  logic       s3,
    input  logic       s2,
    input  logic       s1,
    output logic [1:0] motor,
    output logic [1:0] floor,
    output logic [3:0] pending,
    output logic       door_open,
    output logic       fault
);

    localparam int DWELL_W   = (DWELL_CYCLES   > 1) ? $clog2(DWELL_CYCLES)   : 1;
    localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DWELL_W-1:0]   DWELL_LOAD   = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_e     state, state_next;
    logic       dir_up, dir_up_next;
    logic [1:0] floor_next, sensor_floor, svc_floor;
    logic [3:0] pending_next;
    logic       sensor_valid, arrival, above, below;
    logic       dwell_load, dwell_zero, travel_load, travel_zero, moving;

    // Sensor vector counts only when exactly one sensor is high.
    always_comb begin
        sensor_valid = 1'b1;
        sensor_floor = floor;
        case ({s4, s3, s2, s1})
            4'b0001: sensor_floor = 2'd0;
            4'b0010: sensor_floor = 2'd1;
            4'b0100: sensor_floor = 2'd2;
            4'b1000: sensor_floor = 2'd3;
            default: sensor_valid = 1'b0;
        endcase
    end

    assign floor_next = sensor_valid ? sensor_floor : floor;
    // An arrival is a valid sensor at a floor other than the one we left.
    assign arrival    = sensor_valid && (sensor_floor != floor);
    assign above      = pending_above(pending, floor);
    assign below      = pending_below(pending, floor);
    assign moving     = (state == ST_UP) || (state == ST_DOWN);
    // Floor whose call is serviced when the door opens.
    assign svc_floor  = moving ? sensor_floor : floor;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pending[floor])  state_next = ST_DOOR;
                else if (above)      state_next = ST_UP;
                else if (below)      state_next = ST_DOWN;
            end
            ST_UP: begin
                if (arrival && pending[sensor_floor]) state_next = ST_DOOR;
                else if (floor_next == TOP_FLOOR)     state_next = ST_IDLE;
                else if (!arrival && travel_zero)     state_next = ST_FAULT;
            end
            ST_DOWN: begin
                if (arrival && pending[sensor_floor]) state_next = ST_DOOR;
                else if (floor_next == BOTTOM_FLOOR)  state_next = ST_IDLE;
                else if (!arrival && travel_zero)     state_next = ST_FAULT;
            end
            ST_DOOR: begin
                // SCAN: keep going the same way while calls remain ahead.
                if (dwell_zero) begin
                    if (dir_up)      state_next = above ? ST_UP   : (below ? ST_DOWN : ST_IDLE);
                    else             state_next = below ? ST_DOWN : (above ? ST_UP   : ST_IDLE);
                end
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dir_up_next = dir_up;
        if (state_next == ST_UP)   dir_up_next = 1'b1;
        if (state_next == ST_DOWN) dir_up_next = 1'b0;
    end

    // Presses latch; the serviced floor's bit is held clear while the door
    // is open so presses there are absorbed.
    always_comb begin
        pending_next = pending | select_floor;
        if (state == ST_DOOR || state_next == ST_DOOR) pending_next[svc_floor] = 1'b0;
    end

    assign dwell_load  = (state_next == ST_DOOR) && (state != ST_DOOR);
    assign travel_load = ((state_next == ST_UP || state_next == ST_DOWN) && state_next != state)
                         || (moving && arrival);

    elev_timer #(.WIDTH(DWELL_W)) u_dwell_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (dwell_load),
        .en         (state == ST_DOOR),
        .load_value (DWELL_LOAD),
        .zero       (dwell_zero)
    );

    elev_timer #(.WIDTH(TIMEOUT_W)) u_travel_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (travel_load),
        .en         (moving),
        .load_value (TIMEOUT_LOAD),
        .zero       (travel_zero)
    );

    // NOTE: the asynchronous reset reaches the motor flop directly, so the
    // motor stops the moment rst rises rather than at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            dir_up    <= 1'b1;
            floor     <= 2'd0;
            pending   <= 4'b0000;
            motor     <= MOTOR_STOP;
            door_open <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_next;
            dir_up    <= dir_up_next;
            floor     <= floor_next;
            pending   <= pending_next;
            motor     <= motor_of(state_next);
            door_open <= (state_next == ST_DOOR);
            fault     <= (state_next == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler (DWELL_CYCLES=8, TIMEOUT_CYCLES=64).
// Rows of {select, sensors, repeat count, expected outputs} are stepped one
// clock at a time; each expectation is queued when its stimulus is driven and
// popped when the DUT output is sampled 1 time unit after the rising edge.
module tb_elevator_scheduler;

    typedef struct packed {
        logic [1:0] motor;
        logic [1:0] floor;
        logic [3:0] pending;
        logic       door_open;
        logic       fault;
    } outs_t;

    typedef struct {
        string      name;
        logic [3:0] sel;
        logic [3:0] sens;
        int         reps;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] select_floor;
    logic       s4, s3, s2, s1;
    logic [1:0] motor, floor;
    logic [3:0] pending;
    logic       door_open, fault;

    vec_t  vecs[$];
    outs_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    elevator_scheduler #(.DWELL_CYCLES(8), .TIMEOUT_CYCLES(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .select_floor (select_floor),
        .s4           (s4),
        .s3           (s3),
        .s2           (s2),
        .s1           (s1),
        .motor        (motor),
        .floor        (floor),
        .pending      (pending),
        .door_open    (door_open),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic outs_t sample();
        return '{motor: motor, floor: floor, pending: pending, door_open: door_open, fault: fault};
    endfunction

    task automatic check(input string name, input outs_t act, input outs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got motor=%b floor=%0d pending=%b door=%b fault=%b, want motor=%b floor=%0d pending=%b door=%b fault=%b",
                     name, act.motor, act.floor, act.pending, act.door_open, act.fault,
                     exp.motor, exp.floor, exp.pending, exp.door_open, exp.fault);
        end
    endtask

    task automatic add(input string name, input logic [3:0] sel, input logic [3:0] sens,
                       input int reps, input logic [1:0] m, input logic [1:0] f,
                       input logic [3:0] p, input logic d, input logic flt);
        vec_t v;
        v.name = name;
        v.sel  = sel;
        v.sens = sens;
        v.reps = reps;
        v.exp  = '{motor: m, floor: f, pending: p, door_open: d, fault: flt};
        vecs.push_back(v);
    endtask

    task automatic run_vecs();
        foreach (vecs[k]) begin
            for (int r = 0; r < vecs[k].reps; r++) begin
                @(negedge clk);
                select_floor     = vecs[k].sel;
                {s4, s3, s2, s1} = vecs[k].sens;
                exp_q.push_back(vecs[k].exp);
                @(posedge clk);
                #1;
                check($sformatf("%s[%0d]", vecs[k].name, r), sample(), exp_q.pop_front());
            end
        end
        vecs.delete();
    endtask

    task automatic check_reset(input string name);
        exp_q.push_back('0);
        check(name, sample(), exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b1;
        select_floor = 4'b0000;
        {s4, s3, s2, s1} = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Basic trip 0 -> 2 with invalid sensor vectors mid-travel.
        add("trip_press", 4'b0100, 4'b0001,  1, 2'b00, 2'd0, 4'b0100, 1'b0, 1'b0);
        add("trip_up0",   4'b0000, 4'b0001,  9, 2'b01, 2'd0, 4'b0100, 1'b0, 1'b0);
        add("trip_bad",   4'b0000, 4'b0110,  5, 2'b01, 2'd0, 4'b0100, 1'b0, 1'b0);
        add("trip_f1",    4'b0000, 4'b0010, 10, 2'b01, 2'd1, 4'b0100, 1'b0, 1'b0);
        add("trip_bad2",  4'b0000, 4'b1100,  5, 2'b01, 2'd1, 4'b0100, 1'b0, 1'b0);
        add("trip_arr2",  4'b0000, 4'b0100,  1, 2'b00, 2'd2, 4'b0000, 1'b1, 1'b0);
        add("trip_dwell", 4'b0000, 4'b0100,  7, 2'b00, 2'd2, 4'b0000, 1'b1, 1'b0);
        add("trip_idle",  4'b0000, 4'b0100,  3, 2'b00, 2'd2, 4'b0000, 1'b0, 1'b0);
        // Down to 1, current-floor presses absorbed during the door.
        add("dn_press",   4'b0010, 4'b0100,  1, 2'b00, 2'd2, 4'b0010, 1'b0, 1'b0);
        add("dn_go",      4'b0000, 4'b0100,  4, 2'b10, 2'd2, 4'b0010, 1'b0, 1'b0);
        add("dn_gap",     4'b0000, 4'b0000,  3, 2'b10, 2'd2, 4'b0010, 1'b0, 1'b0);
        add("dn_arr1",    4'b0000, 4'b0010,  1, 2'b00, 2'd1, 4'b0000, 1'b1, 1'b0);
        add("door_absorb",4'b0010, 4'b0010,  7, 2'b00, 2'd1, 4'b0000, 1'b1, 1'b0);
        add("door_end",   4'b0000, 4'b0010,  2, 2'b00, 2'd1, 4'b0000, 1'b0, 1'b0);
        // Up 1 -> 3, floor 0 pressed while passing 2, then reverse to 0.
        add("up3_press",  4'b1000, 4'b0010,  1, 2'b00, 2'd1, 4'b1000, 1'b0, 1'b0);
        add("up3_go",     4'b0000, 4'b0010,  3, 2'b01, 2'd1, 4'b1000, 1'b0, 1'b0);
        add("up3_gap",    4'b0000, 4'b0000,  2, 2'b01, 2'd1, 4'b1000, 1'b0, 1'b0);
        add("up3_pass2",  4'b0001, 4'b0100,  1, 2'b01, 2'd2, 4'b1001, 1'b0, 1'b0);
        add("up3_at2",    4'b0000, 4'b0100,  3, 2'b01, 2'd2, 4'b1001, 1'b0, 1'b0);
        add("up3_gap2",   4'b0000, 4'b0000,  2, 2'b01, 2'd2, 4'b1001, 1'b0, 1'b0);
        add("up3_arr3",   4'b0000, 4'b1000,  1, 2'b00, 2'd3, 4'b0001, 1'b1, 1'b0);
        add("up3_dwell",  4'b0000, 4'b1000,  7, 2'b00, 2'd3, 4'b0001, 1'b1, 1'b0);
        add("rev_down",   4'b0000, 4'b1000,  1, 2'b10, 2'd3, 4'b0001, 1'b0, 1'b0);
        add("rev_gap",    4'b0000, 4'b0000,  2, 2'b10, 2'd3, 4'b0001, 1'b0, 1'b0);
        add("rev_f2",     4'b0000, 4'b0100,  2, 2'b10, 2'd2, 4'b0001, 1'b0, 1'b0);
        add("rev_f1",     4'b0000, 4'b0010,  2, 2'b10, 2'd1, 4'b0001, 1'b0, 1'b0);
        add("rev_arr0",   4'b0000, 4'b0001,  1, 2'b00, 2'd0, 4'b0000, 1'b1, 1'b0);
        add("rev_dwell",  4'b0000, 4'b0001,  7, 2'b00, 2'd0, 4'b0000, 1'b1, 1'b0);
        add("rev_idle",   4'b0000, 4'b0001,  2, 2'b00, 2'd0, 4'b0000, 1'b0, 1'b0);
        // Reach floor 2, then simultaneous calls above and below: up first.
        add("pri_press2", 4'b0100, 4'b0001,  1, 2'b00, 2'd0, 4'b0100, 1'b0, 1'b0);
        add("pri_up",     4'b0000, 4'b0001,  2, 2'b01, 2'd0, 4'b0100, 1'b0, 1'b0);
        add("pri_f1",     4'b0000, 4'b0010,  2, 2'b01, 2'd1, 4'b0100, 1'b0, 1'b0);
        add("pri_arr2",   4'b0000, 4'b0100,  1, 2'b00, 2'd2, 4'b0000, 1'b1, 1'b0);
        add("pri_dwell",  4'b0000, 4'b0100,  7, 2'b00, 2'd2, 4'b0000, 1'b1, 1'b0);
        add("pri_idle",   4'b0000, 4'b0100,  1, 2'b00, 2'd2, 4'b0000, 1'b0, 1'b0);
        add("pri_both",   4'b1001, 4'b0100,  1, 2'b00, 2'd2, 4'b1001, 1'b0, 1'b0);
        add("pri_upwin",  4'b0000, 4'b0100,  1, 2'b01, 2'd2, 4'b1001, 1'b0, 1'b0);
        add("pri_arr3",   4'b0000, 4'b1000,  1, 2'b00, 2'd3, 4'b0001, 1'b1, 1'b0);
        add("pri_dwell3", 4'b0000, 4'b1000,  7, 2'b00, 2'd3, 4'b0001, 1'b1, 1'b0);
        add("pri_down",   4'b0000, 4'b1000,  1, 2'b10, 2'd3, 4'b0001, 1'b0, 1'b0);
        add("pri_f2",     4'b0000, 4'b0100,  1, 2'b10, 2'd2, 4'b0001, 1'b0, 1'b0);
        add("pri_f1",     4'b0000, 4'b0010,  1, 2'b10, 2'd1, 4'b0001, 1'b0, 1'b0);
        add("pri_arr0",   4'b0000, 4'b0001,  1, 2'b00, 2'd0, 4'b0000, 1'b1, 1'b0);
        add("pri_dwell0", 4'b0000, 4'b0001,  7, 2'b00, 2'd0, 4'b0000, 1'b1, 1'b0);
        add("pri_idle0",  4'b0000, 4'b0001,  1, 2'b00, 2'd0, 4'b0000, 1'b0, 1'b0);
        // Park at 1, then travel up with the sensor stuck at 1 -> timeout.
        add("to_press1",  4'b0010, 4'b0001,  1, 2'b00, 2'd0, 4'b0010, 1'b0, 1'b0);
        add("to_up",      4'b0000, 4'b0001,  1, 2'b01, 2'd0, 4'b0010, 1'b0, 1'b0);
        add("to_arr1",    4'b0000, 4'b0010,  1, 2'b00, 2'd1, 4'b0000, 1'b1, 1'b0);
        add("to_dwell",   4'b0000, 4'b0010,  7, 2'b00, 2'd1, 4'b0000, 1'b1, 1'b0);
        add("to_idle",    4'b0000, 4'b0010,  1, 2'b00, 2'd1, 4'b0000, 1'b0, 1'b0);
        add("to_press3",  4'b1000, 4'b0010,  1, 2'b00, 2'd1, 4'b1000, 1'b0, 1'b0);
        add("to_stuck",   4'b0000, 4'b0010, 64, 2'b01, 2'd1, 4'b1000, 1'b0, 1'b0);
        add("to_fault",   4'b0000, 4'b0010,  1, 2'b00, 2'd1, 4'b1000, 1'b0, 1'b1);
        add("flt_press",  4'b0101, 4'b0010,  1, 2'b00, 2'd1, 4'b1101, 1'b0, 1'b1);
        add("flt_hold",   4'b0000, 4'b0010,  3, 2'b00, 2'd1, 4'b1101, 1'b0, 1'b1);
        run_vecs();

        // Reset clears the sticky fault and the latched calls.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("fault_reset");
        @(negedge clk);
        {s4, s3, s2, s1} = 4'b0100;
        rst = 1'b0;

        // Head down from 2, then reset asynchronously mid-cycle.
        add("ar_floor2",  4'b0000, 4'b0100,  1, 2'b00, 2'd2, 4'b0000, 1'b0, 1'b0);
        add("ar_press0",  4'b0001, 4'b0100,  1, 2'b00, 2'd2, 4'b0001, 1'b0, 1'b0);
        add("ar_down",    4'b0000, 4'b0100,  2, 2'b10, 2'd2, 4'b0001, 1'b0, 1'b0);
        run_vecs();
        #2;
        rst = 1'b1;
        #1;
        check_reset("async_reset");
        @(posedge clk);
        #1;
        check_reset("reset_held");
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
